vga_plot_arbiter: RTL and testbench

- Shares the single VGA plot port (x, y, colour, plot into the 160x120 adapter) among independent draw engines: ball, brick, platform, loader and full-screen image.
- Grants one requester at a time for a whole burst, either round-robin or with a top-index override.
- Forwards the owner's pixel stream through one register stage and can force the colour to black for erase passes.
- Revokes a grant that overruns a cycle budget and flags the overrun.
- Sits between the draw engines and the `draw` VGA wrapper, replacing ad-hoc mux select sequencing.

---
 rtl/vga_plot_arbiter_pkg.sv | 32 +++
 rtl/vga_plot_arbiter_rr_pick.sv | 37 +++
 rtl/vga_plot_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_plot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_plot_arbiter_pkg
// Brief   : Shared states, requester indices and helpers for the VGA plot arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package vga_plot_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACTIVE  = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam int REQ_BALL   = 0;
  localparam int REQ_BRICK  = 1;
  localparam int REQ_PLAT   = 2;
  localparam int REQ_LOAD   = 3;
  localparam int REQ_SCREEN = 4;

  localparam int CNT_W = 20;
  localparam int IDX_W = 3;

  localparam logic [CNT_W-1:0] DEFAULT_MAX_BURST = 20'd65535;

  // Increment an index with wrap back to zero at n.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_plot_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : vga_plot_arbiter_rr_pick
// Brief   : Combinational round-robin winner pick with optional top-index override.
// Revision: 1.0 - initial release
// ============================================================================
module vga_plot_arbiter_rr_pick
  import vga_plot_arbiter_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  input  logic             ovr_en_i,
  output logic [IDX_W-1:0] win_o,
  output logic             valid_o
);

  logic [IDX_W:0] idx;

  // Scan offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    win_o   = '0;
    idx     = '0;
    valid_o = |req_i;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_i} + (IDX_W + 1)'(k);
      if (idx >= (IDX_W + 1)'(N)) idx = idx - (IDX_W + 1)'(N);
      for (int j = 0; j < N; j++) begin
        if (idx == (IDX_W + 1)'(j) && req_i[j]) win_o = idx[IDX_W-1:0];
      end
    end
    if (ovr_en_i && req_i[N-1]) win_o = IDX_W'(N - 1);
  end

endmodule
`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vga_plot_arbiter
// Brief   : Burst arbiter sharing one registered VGA plot port among draw engines.
// Revision: 1.0 - initial release
// ============================================================================
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int               N            = 5,
  parameter logic [CNT_W-1:0] MAX_BURST    = DEFAULT_MAX_BURST,
  parameter bit               TOP_OVERRIDE = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N-1:0]      req_i,
  input  logic [N-1:0]      done_i,
  input  logic [N-1:0]      erase_i,
  input  logic [10*N-1:0]   x_in_i,
  input  logic [10*N-1:0]   y_in_i,
  input  logic [3*N-1:0]    colour_in_i,
  input  logic [N-1:0]      plot_in_i,
  output logic [N-1:0]      grant_o,
  output logic [9:0]        x_o,
  output logic [9:0]        y_o,
  output logic [2:0]        colour_o,
  output logic              plot_o,
  output logic              busy_o,
  output logic              timeout_err_o,
  output logic [2:0]        err_id_o
);

  localparam logic [CNT_W-1:0] LAST_CYC = MAX_BURST - {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             erase_q, erase_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [2:0]       colour_q, colour_d;
  logic             plot_q, plot_d;
  logic             terr_q, terr_d;
  logic [2:0]       err_id_q, err_id_d;

  logic [IDX_W-1:0] pick_win;
  logic             pick_valid;
  logic             pick_erase;
  logic [9:0]       own_x, own_y;
  logic [2:0]       own_col;
  logic             own_plot, own_done;

  vga_plot_arbiter_rr_pick #(.N(N)) u_pick (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr_q),
    .ovr_en_i (TOP_OVERRIDE),
    .win_o    (pick_win),
    .valid_o  (pick_valid)
  );

  always_comb begin
    own_x      = '0;
    own_y      = '0;
    own_col    = '0;
    own_plot   = 1'b0;
    own_done   = 1'b0;
    pick_erase = 1'b0;
    grant_o    = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_x    = x_in_i[10*i +: 10];
        own_y    = y_in_i[10*i +: 10];
        own_col  = colour_in_i[3*i +: 3];
        own_plot = plot_in_i[i];
        own_done = done_i[i];
        grant_o[i] = (state_q == ARB_ACTIVE);
      end
      if (pick_win == IDX_W'(i)) pick_erase = erase_i[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    erase_d  = erase_q;
    ovr_d    = ovr_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    terr_d   = terr_q;
    err_id_d = err_id_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_ACTIVE;
          owner_d = pick_win;
          erase_d = pick_erase;
          ovr_d   = TOP_OVERRIDE && req_i[N-1];
          cnt_d   = '0;
        end
      end
      ARB_ACTIVE: begin
        x_d      = own_x;
        y_d      = own_y;
        colour_d = erase_q ? 3'b000 : own_col;
        if (own_done) begin
          plot_d  = own_plot;
          state_d = ARB_RELEASE;
        end else if (cnt_q == LAST_CYC) begin
          // Budget exhausted: this cycle's pixel is discarded.
          terr_d   = 1'b1;
          err_id_d = owner_q;
          state_d  = ARB_RELEASE;
        end else begin
          plot_d = own_plot;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
        if (!ovr_q) rr_ptr_d = wrap_inc(owner_q, N);
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      erase_q  <= 1'b0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      terr_q   <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      erase_q  <= erase_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      terr_q   <= terr_d;
      err_id_q <= err_id_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign colour_o      = colour_q;
  assign plot_o        = plot_q;
  assign busy_o        = (state_q != ARB_IDLE);
  assign timeout_err_o = terr_q;
  assign err_id_o      = err_id_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_plot_arbiter
// Brief   : Scoreboard bench for the VGA plot arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_plot_arbiter;

  localparam int N    = 5;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [N-1:0]    req_r, done_r, erase_r, plot_r;
  logic [10*N-1:0] x_r, y_r;
  logic [3*N-1:0]  col_r;

  logic [N-1:0] grant_o;
  logic [9:0]   x_o, y_o;
  logic [2:0]   colour_o;
  logic         plot_o, busy_o, timeout_err_o;
  logic [2:0]   err_id_o;

  vga_plot_arbiter #(
    .N(N), .MAX_BURST(20'(MAXB)), .TOP_OVERRIDE(1'b1)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_i(req_r), .done_i(done_r), .erase_i(erase_r),
    .x_in_i(x_r), .y_in_i(y_r), .colour_in_i(col_r), .plot_in_i(plot_r),
    .grant_o(grant_o), .x_o(x_o), .y_o(y_o), .colour_o(colour_o),
    .plot_o(plot_o), .busy_o(busy_o),
    .timeout_err_o(timeout_err_o), .err_id_o(err_id_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  c;
    logic [31:0] at;
  } px_t;

  px_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!resetn && plot_o) begin
      if (sb.size() == 0) check("unexpected_plot", 32'(plot_o), 0);
      else begin
        px_t e;
        e = sb.pop_front();
        check("px_x", 32'(x_o), 32'(e.x));
        check("px_y", 32'(y_o), 32'(e.y));
        check("px_colour", 32'(colour_o), 32'(e.c));
        check("px_cycle", 32'(cyc), e.at);
      end
    end
  end

  task automatic clear_inputs();
    req_r = '0; done_r = '0; erase_r = '0; plot_r = '0;
    x_r = '0; y_r = '0; col_r = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
  endtask

  // Raise req for id, wait for any grant and confirm it went to id.
  task automatic grab(input int id, input bit ers, input bit hold, input int exp_lat);
    int lat;
    logic [N-1:0] oh;
    lat = 0;
    oh = N'(1) << id;
    req_r[id] = 1'b1;
    erase_r[id] = ers;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (grant_o == '0 && lat < 40);
    check("grant_who", 32'(grant_o), 32'(oh));
    if (exp_lat > 0) check("grant_lat", lat, exp_lat);
    if (!hold) req_r[id] = 1'b0;
    erase_r[id] = 1'b0;
  endtask

  // Owner drives npix pixels with done on the last one.
  task automatic stream(input int id, input int npix, input logic [9:0] x0,
                        input logic [9:0] y0, input logic [2:0] col, input bit ers);
    logic [N-1:0] oh;
    oh = N'(1) << id;
    for (int i = 0; i < npix; i++) begin
      check("grant_hold", 32'(grant_o), 32'(oh));
      x_r[10*id +: 10] = x0 + 10'(i);
      y_r[10*id +: 10] = y0;
      col_r[3*id +: 3] = col;
      plot_r[id] = 1'b1;
      done_r[id] = (i == npix - 1);
      sb.push_back('{x: x0 + 10'(i), y: y0, c: (ers ? 3'b000 : col), at: 32'(cyc + 1)});
      @(posedge clk); #1;
    end
    plot_r[id] = 1'b0;
    done_r[id] = 1'b0;
    check("rel_grant", 32'(grant_o), 0);
    check("rel_busy", 32'(busy_o), 1);
  endtask

  initial begin
    int i;
    clear_inputs();
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_plot", 32'(plot_o), 0);
    check("rst_x", 32'(x_o), 0);
    check("rst_colour", 32'(colour_o), 0);
    check("rst_terr", 32'(timeout_err_o), 0);
    check("rst_errid", 32'(err_id_o), 0);
    resetn = 1'b0;

    // Basic burst; a non-owner plots junk and strobes done meanwhile.
    plot_r[4] = 1'b1;
    x_r[49:40] = 10'h3ff;
    done_r[2] = 1'b1;
    grab(0, 1'b0, 1'b0, 1);
    stream(0, 4, 10'd10, 10'd20, 3'b100, 1'b0);
    plot_r[4] = 1'b0;
    done_r[2] = 1'b0;

    // Round-robin with three requesters held high throughout.
    do_reset();
    req_r = 5'b00111;
    grab(0, 1'b0, 1'b1, 1); stream(0, 2, 10'd100, 10'd1, 3'b001, 1'b0);
    grab(1, 1'b0, 1'b1, 2); stream(1, 2, 10'd110, 10'd2, 3'b010, 1'b0);
    grab(2, 1'b0, 1'b1, 2); stream(2, 2, 10'd120, 10'd3, 3'b011, 1'b0);
    grab(0, 1'b0, 1'b1, 2); stream(0, 2, 10'd130, 10'd4, 3'b101, 1'b0);
    req_r = '0;

    // Override: pointer sits at 2, requester 4 jumps ahead and leaves it there.
    do_reset();
    grab(1, 1'b0, 1'b0, 1); stream(1, 1, 10'd5, 10'd5, 3'b110, 1'b0);
    req_r[2] = 1'b1;
    grab(4, 1'b0, 1'b0, 2);
    req_r[0] = 1'b1;
    stream(4, 2, 10'd200, 10'd100, 3'b111, 1'b0);
    grab(2, 1'b0, 1'b0, 2); stream(2, 1, 10'd300, 10'd101, 3'b010, 1'b0);
    grab(0, 1'b0, 1'b0, 2); stream(0, 1, 10'd301, 10'd102, 3'b001, 1'b0);

    // Erase burst then a normal burst from the same requester.
    grab(1, 1'b1, 1'b0, 2); stream(1, 3, 10'd30, 10'd40, 3'b111, 1'b1);
    grab(1, 1'b0, 1'b0, 2); stream(1, 2, 10'd30, 10'd41, 3'b111, 1'b0);

    // Timeout: requester 3 never signals done.
    grab(3, 1'b0, 1'b0, 2);
    i = 0;
    while (grant_o[3] && i < 20) begin
      x_r[39:30] = 10'd500 + 10'(i);
      y_r[39:30] = 10'd60;
      col_r[11:9] = 3'b011;
      plot_r[3] = 1'b1;
      if (i < MAXB - 1)
        sb.push_back('{x: 10'd500 + 10'(i), y: 10'd60, c: 3'b011, at: 32'(cyc + 1)});
      if (i == 2) req_r[0] = 1'b1;
      @(posedge clk); #1;
      i++;
    end
    plot_r[3] = 1'b0;
    check("to_cycles", i, MAXB);
    check("to_err", 32'(timeout_err_o), 1);
    check("to_errid", 32'(err_id_o), 3);
    check("to_busy", 32'(busy_o), 1);
    grab(0, 1'b0, 1'b0, 2); stream(0, 1, 10'd7, 10'd8, 3'b100, 1'b0);
    check("to_sticky", 32'(timeout_err_o), 1);

    // Asynchronous reset in the middle of a burst.
    grab(2, 1'b0, 1'b0, 2);
    x_r[29:20] = 10'd50; y_r[29:20] = 10'd51; col_r[8:6] = 3'b101; plot_r[2] = 1'b1;
    sb.push_back('{x: 10'd50, y: 10'd51, c: 3'b101, at: 32'(cyc + 1)});
    @(posedge clk); #1;
    #5;
    check("pre_rst_busy", 32'(busy_o), 1);
    resetn = 1'b1;
    #1;
    check("arst_grant", 32'(grant_o), 0);
    check("arst_busy", 32'(busy_o), 0);
    check("arst_plot", 32'(plot_o), 0);
    check("arst_x", 32'(x_o), 0);
    check("arst_y", 32'(y_o), 0);
    check("arst_colour", 32'(colour_o), 0);
    check("arst_terr", 32'(timeout_err_o), 0);
    check("arst_errid", 32'(err_id_o), 0);
    clear_inputs();
    @(posedge clk); #1;
    resetn = 1'b0;
    req_r[1] = 1'b1;
    grab(0, 1'b0, 1'b0, 1); stream(0, 1, 10'd70, 10'd71, 3'b001, 1'b0);
    grab(1, 1'b0, 1'b0, 2); stream(1, 1, 10'd72, 10'd73, 3'b010, 1'b0);
    check("post_terr", 32'(timeout_err_o), 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
